pipeline_stage_chain: RTL
=========================

Name: pipeline_stage_chain

Overview:
- Parametrised chain of pipeline registers for the staged MIPS datapath. One instance replaces the hand-wired IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
- Each stage holds a valid bit plus a DATA_WIDTH payload. The payload is the concatenated control and data fields for that boundary.
- Adds per-stage stall and flush, with automatic bubble (NOP) injection behind a stall.
- Adds a saturating counter of stall bubbles for performance monitoring.

Parameters:
DATA_WIDTH, 32, payload width per stage in bits
STAGES, 4, number of register stages (>=2); stage 0 is nearest the input
RESET_VALUE, 0, payload value loaded on reset and into every bubble (all-zero = NOP control)
CNT_WIDTH, 16, width of bubble_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a payload to enter stage 0
in_data  input  DATA_WIDTH  payload entering stage 0
in_ready  output  1  stage 0 accepts in_data this cycle
stall  input  STAGES  stall[i]=1: stage i content cannot advance this cycle
flush  input  STAGES  flush[i]=1: stage i becomes a bubble at this edge
stage_valid  output  STAGES  valid bit of each stage
stage_data  output  STAGES*DATA_WIDTH  stage i payload at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  equals stage_valid[STAGES-1]
out_data  output  DATA_WIDTH  equals payload of stage STAGES-1
bubble_count  output  CNT_WIDTH  saturating count of stall-injected bubbles

Behaviour:
- Reset (evaluated at the clock edge):
  - All stage_valid = 0; all payloads = RESET_VALUE; bubble_count = 0.
  - Reset overrides stall, flush and in_valid at the same edge.
  - Reset mid-stream discards all in-flight content; no partial state survives.
- Freeze: freeze[i] = OR of stall[j] for j = i..STAGES-1.
  - A stall in stage k freezes stages 0..k (MIPS load-use semantics).
- in_ready = !freeze[0], combinational. in_data is consumed only at edges where in_valid && in_ready.
  - When in_ready=0, upstream must hold in_data; it is not lost.
- Next state of stage i, in priority order:
  1. flush[i]=1: valid <= 0, payload <= RESET_VALUE. Applies whether stage i is frozen or not.
  2. freeze[i]=1: hold valid and payload.
  3. i = 0: valid <= in_valid, payload <= in_data. If in_valid=0, payload <= RESET_VALUE.
  4. i > 0 and freeze[i-1]=1 (so stall sits exactly at i-1): inject bubble, valid <= 0, payload <= RESET_VALUE.
  5. Otherwise: copy valid and payload from stage i-1.
- An invalid stage always carries RESET_VALUE, so downstream control decodes as NOP.
- Latency: with no stall or flush, in_data accepted at edge n appears on out_data after edge n+STAGES-1, i.e. STAGES register stages.
  - Full throughput: one payload per cycle.
- stall[STAGES-1]=1 freezes the whole chain. out_data and out_valid hold, in_ready=0, and no bubble is generated.
- bubble_count: +1 at each edge where some stage i>0 takes rule 4 (at most one bubble position per cycle).
  - Rule 4 is counted even if flush[i] also applies at that stage.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - Flush-created bubbles are not counted.
- Simultaneous stall[i] and flush[i]: stage i is cleared (flush wins). Stages below i still freeze; stage i+1 still receives a bubble.
- Outputs are registered only, except in_ready, which is a combinational function of stall.

Test Plan:
- Defaults, reset 2 cycles, then in_valid=1 with in_data 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> out_valid rises with out_data=0x11 after the 4th edge, then 0x22..0x55 on consecutive cycles; bubble_count=0.
- Stages s0..s3 = 0x44,0x33,0x22,0x11; pulse stall[1] one cycle with in_data=0x55 -> in_ready=0 that cycle. Next state: s0=0x44, s1=0x33, s2 valid=0 data=0, s3=0x22, bubble_count=1. Following cycle s0=0x55 enters.
- Same filled state; flush[0]=flush[1]=1 (taken branch) -> s0 and s1 invalid with data=0, s2=0x33, s3=0x22; bubble_count unchanged.
- stall[1]=flush[1]=1 together -> s0 holds 0x44, s1 invalid/0, s2 invalid/0, s3=0x22, bubble_count +1.
- stall[3] held 3 cycles -> out_data stable at 0x11, all stages hold, in_ready=0 throughout, bubble_count unchanged.
- CNT_WIDTH=2, five single-cycle stall[0] pulses separated by idle cycles -> bubble_count reads 1,2,3,3,3. Then assert reset together with stall[2] -> next edge all stage_valid=0, payloads=0, bubble_count=0.

Source files
------------

// File: rtl/pipeline_stage_chain.sv
// Purpose : parametrised chain of valid+payload pipeline registers for the
//           staged MIPS datapath. Supports per-stage stall and flush. A stall
//           injects a bubble (NOP) into the stage behind it. A saturating
//           counter tracks how many stall bubbles have been injected.
// Ports   : clk, reset     - rising-edge clock, synchronous active-high reset
//           in_valid/in_data/in_ready - upstream handshake into stage 0
//           stall, flush   - per-stage stall / flush requests
//           stage_valid, stage_data - every stage's valid bit and payload
//                            (stage i payload at [i*DATA_WIDTH +: DATA_WIDTH])
//           out_valid, out_data - last stage
//           bubble_count   - saturating count of stall-injected bubbles
module pipeline_stage_chain #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           STAGES      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall,
    input  logic [STAGES-1:0]            flush,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*DATA_WIDTH-1:0] stage_data,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CNT_WIDTH-1:0]         bubble_count
);

    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     valid_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [STAGES-1:0]     freeze;
    logic                  bubble_c;

    // A stall at stage k freezes every stage at or below k; a bubble appears
    // at the single boundary where a frozen stage feeds an unfrozen one.
    always_comb begin
        freeze   = '0;
        bubble_c = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            freeze[i] = |(stall >> i);
        end
        for (int i = 1; i < STAGES; i++) begin
            if (freeze[i-1] && !freeze[i]) begin
                bubble_c = 1'b1;
            end
        end
    end

    assign in_ready = !freeze[0];

    // Next-state per stage: flush, then hold, then load/bubble/copy.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;

        if (flush[0]) begin
            valid_d[0] = 1'b0;
            data_d[0]  = RESET_VALUE;
        end else if (!freeze[0]) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : RESET_VALUE;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = RESET_VALUE;
            end else if (!freeze[i]) begin
                if (freeze[i-1]) begin
                    valid_d[i] = 1'b0;
                    data_d[i]  = RESET_VALUE;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end
    end

    // State registers and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= RESET_VALUE;
            end
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            if (bubble_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Flatten stage payloads onto the output bus.
    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
        end
    end

    assign stage_valid  = valid_q;
    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign bubble_count = cnt_q;

endmodule
